boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
// - Upstream of twitchcore: receives a program image as a byte stream and writes it word-by-word into the
//   core's 16 KB unified RAM, holding the core in reset until the image is loaded and checksum-verified.
// - Sits between the host byte link (UART RX or testbench) and the RAM data-write port; it releases the core on success.
// PARAMETERS
// - BASE_ADDR  14'h0000  RAM byte address of the first loaded word; must be word-aligned
// - MAX_WORDS  4096      largest accepted word count; counts above it -> ERR
// - TIMEOUT    65535     idle cycles allowed between bytes in LEN0..CSUM before ERR; width = $clog2(TIMEOUT+1)
// - MAGIC      8'hA5     sync byte that starts a frame
// PORTS
// - clk        in   1   clock
// - resetn     in   1   synchronous reset, active-low
// - in_valid   in   1   in_byte valid
// - in_ready   out  1   loader accepts byte; transfer occurs when in_valid && in_ready at posedge
// - in_byte    in   8   stream byte
// - restart    in   1   one-cycle pulse; from DONE/ERR returns to SYNC and re-asserts core_hold
// - mem_we     out  1   one-cycle write strobe; drives RAM dw_size=2'b11 when high, 2'b00 otherwise
// - mem_addr   out  14  RAM byte address, always word-aligned
// - mem_wdata  out  32  write word, little-endian byte assembly
// - core_hold  out  1   1 = keep core in reset; drives twitchcore reset input
// - done       out  1   level: image loaded, checksum matched
// - error      out  1   level: frame rejected
// BEHAVIOUR
// - Reset (resetn=0 at posedge): state=SYNC, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_hold=1,
//   done=0, error=0, counters=0. in_ready=1 from the first cycle after reset deasserts. Reset mid-frame
//   discards all progress; RAM words already written stay written.
// - Frame: MAGIC, LEN_LO, LEN_HI (16-bit word count N), 4*N payload bytes (LSB first per word), CSUM byte
//   = XOR of all payload bytes (header and MAGIC excluded).
// - States: SYNC -> LEN0 -> LEN1 -> DATA -> CSUM -> DONE | ERR.
//   SYNC: non-MAGIC bytes are consumed and dropped; MAGIC -> LEN0.
//   LEN1: N>MAX_WORDS -> ERR; N==0 -> CSUM (expected checksum 0x00); else -> DATA.
//   DATA: shift byte into word register, XOR into checksum, increment byte lane. The 4th byte of a word makes
//   mem_we=1 next cycle with the assembled word at the current mem_addr; mem_addr then advances by 4, wrapping mod 2^14.
//   After word N -> CSUM.
//   CSUM: byte==running XOR -> DONE, else ERR.
//   DONE: core_hold=0, done=1, in_ready=0. ERR: core_hold=1, error=1, in_ready=0.
// - in_ready=1 in SYNC..CSUM; writes never stall input (at most one word per 4 accepted bytes).
// - Timeout: counter clears on each accepted byte, counts while in LEN0..CSUM; reaching TIMEOUT -> ERR. Not active in SYNC.
// - restart in DONE/ERR: next cycle state=SYNC, done=error=0, core_hold=1, mem_addr=BASE_ADDR, checksum=0.
//   restart ignored in other states.
// - restart and a byte in the same cycle in DONE/ERR: byte is not accepted (in_ready=0 there).
// - Latency: last payload byte -> mem_we 1 cycle; CSUM byte -> done/core_hold change 1 cycle.
// STRUCTURE
// - Shared package (twitchcore_pkg): RAM_AW=14, BOOT_MAGIC=8'hA5, state enum loader_state_t {SYNC,LEN0,LEN1,DATA,CSUM,DONE,ERR}.
// - One module, no sub-modules; word assembler, checksum and timeout counter are inline.
// TESTING
// - Load N=2: A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 7C -> mem_we pulses at addr 0x0000 data 0x00000013,
//   addr 0x0004 data 0x0000006F; done=1, core_hold=0.
// - Bad checksum: same frame with CSUM 7D -> no change to the two writes, error=1, core_hold=1, done=0.
// - Garbage before sync: 00 FF 5A then valid frame -> three bytes dropped, load identical to the first test.
// - N=0x1001 (> MAX_WORDS) -> ERR right after LEN_HI, no mem_we. N=0: A5 00 00 00 -> DONE, no mem_we.
// - Stall: frame paused 65535 cycles mid-DATA -> error=1; restart pulse -> SYNC, mem_addr=BASE_ADDR, core_hold=1.
// - Reset mid-DATA after 6 bytes -> in_ready=0, core_hold=1 during reset; next full frame loads from BASE_ADDR.

Source files
------------

// File: rtl/twitchcore_pkg.sv
// Shared definitions for the twitchcore boot path.
// Contents: RAM address width, default frame sync byte, loader state type
// and small state-classification helpers used by the boot loader.
package twitchcore_pkg;

    localparam int         RAM_AW     = 14;
    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    // States in which the byte link is open.
    function automatic logic accepts_bytes(input loader_state_t s);
        return s inside {SYNC, LEN0, LEN1, DATA, CSUM};
    endfunction

    // States in which the inter-byte idle timer runs.
    function automatic logic timer_active(input loader_state_t s);
        return s inside {LEN0, LEN1, DATA, CSUM};
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes
// it word-by-word into the core RAM and keeps the core in reset until the
// image is loaded and its XOR checksum verified.
//
// Frame: MAGIC, LEN_LO, LEN_HI (word count N), 4*N payload bytes (LSB first
// per word), CSUM (XOR of all payload bytes).
//
// Ports:
//   clk        clock
//   resetn     synchronous reset, active-low
//   in_valid   in_byte valid
//   in_ready   loader accepts a byte (transfer on in_valid && in_ready)
//   in_byte    stream byte
//   restart    pulse; from DONE/ERR returns to SYNC
//   mem_we     one-cycle RAM write strobe
//   mem_addr   RAM byte address (word-aligned)
//   mem_wdata  assembled little-endian write word
//   core_hold  1 = keep core in reset
//   done       image loaded and checksum matched
//   error      frame rejected
module boot_loader
    import twitchcore_pkg::*;
#(
    parameter logic [RAM_AW-1:0] BASE_ADDR = 14'h0000,
    parameter int unsigned       MAX_WORDS = 4096,
    parameter int unsigned       TIMEOUT   = 65535,
    parameter logic [7:0]        MAGIC     = BOOT_MAGIC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              restart,
    output logic              mem_we,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned     TW            = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_LIMIT = TW'(TIMEOUT);
    localparam logic [16:0]     MAX_N         = 17'(MAX_WORDS);

    loader_state_t     state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       words_q, words_d;
    logic [1:0]        lane_q, lane_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              fire;
    logic              restart_ok;
    logic [15:0]       n_word;
    logic [TW-1:0]     tmo_inc;

    assign fire       = in_valid && rdy_q;
    assign restart_ok = restart && (state_q inside {DONE, ERR});
    assign n_word     = {in_byte, len_q[7:0]};
    assign tmo_inc    = tmo_q + TW'(1);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: if (fire && in_byte == MAGIC) state_d = LEN0;
            LEN0: if (fire) state_d = LEN1;
            LEN1: begin
                if (fire) begin
                    if ({1'b0, n_word} > MAX_N) state_d = ERR;
                    else if (n_word == 16'd0)   state_d = CSUM;
                    else                        state_d = DATA;
                end
            end
            DATA: begin
                if (fire && lane_q == 2'd3 && (words_q + 16'd1) == len_q)
                    state_d = CSUM;
            end
            CSUM: if (fire) state_d = (in_byte == csum_q) ? DONE : ERR;
            DONE: if (restart) state_d = SYNC;
            ERR:  if (restart) state_d = SYNC;
            default: state_d = SYNC;
        endcase
        // An accepted byte always resets the idle timer, so it wins over expiry.
        if (timer_active(state_q) && !fire && tmo_inc == TIMEOUT_LIMIT)
            state_d = ERR;
    end

    // ---------------- output logic ----------------
    // in_ready is registered from the next state so it drops together with
    // the entry into DONE/ERR and stays low through the reset cycle.
    always_comb begin
        rdy_d     = accepts_bytes(state_d);
        core_hold = (state_q != DONE);
        done      = (state_q == DONE);
        error     = (state_q == ERR);
    end

    assign in_ready  = rdy_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;

    // ---------------- datapath: assembler, checksum, timer ----------------
    always_comb begin
        we_d    = 1'b0;
        word_d  = word_q;
        csum_d  = csum_q;
        len_d   = len_q;
        words_d = words_q;
        lane_d  = lane_q;
        tmo_d   = (timer_active(state_q) && !fire) ? tmo_inc : '0;
        // Address steps past a word the cycle after its strobe, so the
        // strobe cycle presents the word's own address.
        addr_d  = we_q ? addr_q + RAM_AW'(4) : addr_q;

        case (state_q)
            SYNC: begin
                if (fire && in_byte == MAGIC) begin
                    csum_d  = '0;
                    words_d = '0;
                    lane_d  = '0;
                end
            end
            LEN0: if (fire) len_d = {8'h00, in_byte};
            LEN1: if (fire) len_d = n_word;
            DATA: begin
                if (fire) begin
                    word_d = {in_byte, word_q[31:8]};
                    csum_d = csum_q ^ in_byte;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        words_d = words_q + 16'd1;
                    end
                end
            end
            default: ;
        endcase

        if (restart_ok) begin
            addr_d  = BASE_ADDR;
            csum_d  = '0;
            words_d = '0;
            lane_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            word_q  <= '0;
            csum_q  <= '0;
            len_q   <= '0;
            words_q <= '0;
            lane_q  <= '0;
            tmo_q   <= '0;
        end else begin
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            len_q   <= len_d;
            words_q <= words_d;
            lane_q  <= lane_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames from the block's
// reference vectors plus randomized frames checked against a frame-level
// parser model.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        restart = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;
    int max_gap = 0;

    logic [45:0] got_q[$];
    logic [45:0] exp_q[$];
    bit          exp_done;
    bit          exp_err;

    boot_loader #(
        .BASE_ADDR(14'h0000),
        .MAX_WORDS(4096),
        .TIMEOUT(65535),
        .MAGIC(8'hA5)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_byte(in_byte),
        .restart(restart),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Write monitor: records every strobed {addr, data}.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    end

    // Frame-level reference: locate sync, read length, slice payload into
    // words at consecutive addresses, compare trailing checksum.
    task automatic model_stream(input logic [7:0] s[$]);
        int i, n, p;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        i = 0;
        while (i < s.size() && s[i] !== 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        n = s[i+1] + 256 * s[i+2];
        if (n > 4096) begin
            exp_err = 1;
            return;
        end
        p  = i + 3;
        cs = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (p + 4 > s.size()) return;
            w  = {s[p+3], s[p+2], s[p+1], s[p]};
            cs = cs ^ s[p] ^ s[p+1] ^ s[p+2] ^ s[p+3];
            exp_q.push_back({14'((k * 4) % 16384), w});
            p += 4;
        end
        if (p >= s.size()) return;
        if (s[p] == cs) exp_done = 1;
        else            exp_err  = 1;
    endtask

    // Drives one byte with a random idle gap; called and returns on a negedge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            failures++;
            $display("FAIL send_ready_wait got=in_ready_low exp=in_ready_high byte=%02h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (core_hold !== 1'b1)  begin failures++; $display("FAIL rst_core_hold got=%b exp=1", core_hold); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0)      begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 14'h0)  begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic_load();
        logic [7:0] s[$];
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        max_gap = 2;
        got_q.delete();
        send_stream(s);
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL basic_nwrites got=%0d exp=2", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== {14'h0000, 32'h00000013})
            begin failures++; $display("FAIL basic_write0 got=%h exp=%h", (got_q.size() > 0) ? got_q[0] : 46'h0, {14'h0000, 32'h00000013}); end
        checks++; if (got_q.size() < 2 || got_q[1] !== {14'h0004, 32'h0000006F})
            begin failures++; $display("FAIL basic_write1 got=%h exp=%h", (got_q.size() > 1) ? got_q[1] : 46'h0, {14'h0004, 32'h0000006F}); end
        checks++; if (done !== 1'b1)      begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (core_hold !== 1'b0) begin failures++; $display("FAIL basic_core_hold got=%b exp=0", core_hold); end
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL basic_in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_bad_csum();
        logic [7:0] s[$];
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
        pulse_restart();
        checks++; if (done !== 1'b0 || core_hold !== 1'b1 || mem_addr !== 14'h0)
            begin failures++; $display("FAIL restart_from_done got=d%b h%b a%h exp=d0 h1 a0000", done, core_hold, mem_addr); end
        got_q.delete();
        send_stream(s);
        checks++; if (got_q.size() != 2 || got_q[0] !== {14'h0, 32'h13} || got_q[1] !== {14'h4, 32'h6F})
            begin failures++; $display("FAIL badcs_writes got_n=%0d exp_n=2", got_q.size()); end
        checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1)
            begin failures++; $display("FAIL badcs_status got=e%b d%b h%b exp=e1 d0 h1", error, done, core_hold); end
    endtask

    // Garbage ahead of sync, plus a restart pulse mid-header that must be ignored.
    task automatic test_garbage_sync();
        logic [7:0] a[$], b[$], s[$];
        a = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02};
        b = '{8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        s = {a, b};
        pulse_restart();
        model_stream(s);
        got_q.delete();
        send_stream(a);
        pulse_restart();
        send_stream(b);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL garbage_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++; $display("FAIL garbage_write%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 46'h0, exp_q[k]);
            end
        end
        checks++; if (done !== exp_done || core_hold !== 1'b0) begin failures++; $display("FAIL garbage_done got=%b exp=%b", done, exp_done); end
    endtask

    task automatic test_len_limits();
        logic [7:0] s[$];
        pulse_restart();
        got_q.delete();
        s = '{8'hA5, 8'h01, 8'h10};
        send_stream(s);
        checks++; if (error !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL len_over_err got=e%b r%b exp=e1 r0", error, in_ready); end
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL len_over_nowrite got=%0d exp=0", got_q.size()); end
        pulse_restart();
        s = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_stream(s);
        checks++; if (done !== 1'b1 || core_hold !== 1'b0) begin failures++; $display("FAIL len_zero_done got=d%b h%b exp=d1 h0", done, core_hold); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL len_zero_nowrite got=%0d exp=0", got_q.size()); end
    endtask

    // Largest legal image: fills RAM exactly, address wraps back to base.
    task automatic test_max_words();
        logic [7:0] s[$];
        logic [7:0] cs;
        int bad;
        pulse_restart();
        s = '{8'hA5, 8'h00, 8'h10};
        cs = 8'h00;
        for (int k = 0; k < 4096 * 4; k++) begin
            s.push_back(8'($urandom));
            cs ^= s[s.size() - 1];
        end
        s.push_back(cs);
        max_gap = 0;
        model_stream(s);
        got_q.delete();
        send_stream(s);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL max_nwrites got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        bad = 0;
        foreach (exp_q[k]) begin
            checks++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                failures++;
                if (bad < 4) $display("FAIL max_write%0d got=%h exp=%h", k, (k < got_q.size()) ? got_q[k] : 46'h0, exp_q[k]);
                bad++;
            end
        end
        checks++; if (done !== exp_done) begin failures++; $display("FAIL max_done got=%b exp=%b", done, exp_done); end
        checks++; if (mem_addr !== 14'h0000) begin failures++; $display("FAIL max_addr_wrap got=%h exp=0000", mem_addr); end
    endtask

    task automatic test_random_frames();
        logic [7:0] s[$];
        logic [7:0] b, cs;
        int n;
        for (int f = 0; f < 8; f++) begin
            pulse_restart();
            checks++; if (mem_addr !== 14'h0 || error !== 1'b0 || done !== 1'b0)
                begin failures++; $display("FAIL rand%0d_restart got=a%h e%b d%b exp=a0000 e0 d0", f, mem_addr, error, done); end
            s.delete();
            repeat ($urandom_range(3, 0)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                s.push_back(b);
            end
            n = $urandom_range(6, 0);
            s.push_back(8'hA5);
            s.push_back(8'(n));
            s.push_back(8'h00);
            cs = 8'h00;
            repeat (n * 4) begin
                b = 8'($urandom);
                s.push_back(b);
                cs ^= b;
            end
            if ($urandom_range(2, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
            s.push_back(cs);
            max_gap = 3;
            model_stream(s);
            got_q.delete();
            send_stream(s);
            checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_nwrites got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
            foreach (exp_q[k]) begin
                checks++;
                if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                    failures++; $display("FAIL rand%0d_write%0d got=%h exp=%h", f, k, (k < got_q.size()) ? got_q[k] : 46'h0, exp_q[k]);
                end
            end
            checks++; if (done !== exp_done || error !== exp_err || core_hold !== !exp_done)
                begin failures++; $display("FAIL rand%0d_status got=d%b e%b h%b exp=d%b e%b h%b", f, done, error, core_hold, exp_done, exp_err, !exp_done); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rand%0d_in_ready got=%b exp=0", f, in_ready); end
        end
    endtask

    // restart with a byte in the same cycle: the byte must not be taken.
    task automatic test_restart_collision();
        logic [7:0] s[$];
        restart  = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hA5;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || core_hold !== 1'b1) begin failures++; $display("FAIL collide_restart got=r%b h%b exp=r1 h1", in_ready, core_hold); end
        s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        max_gap = 1;
        model_stream(s);
        got_q.delete();
        send_stream(s);
        checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin failures++; $display("FAIL collide_write got_n=%0d exp=%h", got_q.size(), exp_q[0]); end
        checks++; if (done !== exp_done) begin failures++; $display("FAIL collide_done got=%b exp=%b", done, exp_done); end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        pulse_restart();
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F};
        max_gap = 0;
        got_q.delete();
        send_stream(s);
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", error); end
        @(posedge clk);
        #1;
        checks++; if (error !== 1'b1 || core_hold !== 1'b1) begin failures++; $display("FAIL tmo_expire got=e%b h%b exp=e1 h1", error, core_hold); end
        checks++; if (got_q.size() != 1 || mem_addr !== 14'h0004) begin failures++; $display("FAIL tmo_partial got_n=%0d addr=%h exp_n=1 addr=0004", got_q.size(), mem_addr); end
        @(negedge clk);
        pulse_restart();
        checks++; if (error !== 1'b0 || core_hold !== 1'b1 || mem_addr !== 14'h0000 || in_ready !== 1'b1)
            begin failures++; $display("FAIL tmo_restart got=e%b h%b a%h r%b exp=e0 h1 a0000 r1", error, core_hold, mem_addr, in_ready); end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] a[$], s[$];
        a = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        max_gap = 1;
        send_stream(a);
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || core_hold !== 1'b1) begin failures++; $display("FAIL midrst_outputs got=r%b h%b exp=r0 h1", in_ready, core_hold); end
        resetn = 1'b1;
        @(negedge clk);
        got_q.delete();
        send_stream(s);
        checks++; if (got_q.size() != 2 || got_q[0] !== {14'h0, 32'h13} || got_q[1] !== {14'h4, 32'h6F})
            begin failures++; $display("FAIL midrst_reload got_n=%0d exp_n=2 first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 46'h0); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL midrst_done got=%b exp=1", done); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_csum();
        test_garbage_sync();
        test_len_limits();
        test_random_frames();
        test_restart_collision();
        test_timeout();
        test_reset_mid_data();
        test_max_words();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
